// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
// The slot type is the 2-bit position of a word within a frame.
package tdm_pkg;

  localparam int N_CH  = 4;
  localparam int N_BUF = N_CH - 1;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_t;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_FIRST = 2'd0;
  localparam slot_t SLOT_LAST  = slot_t'(N_CH - 1);

  function automatic slot_t slot_inc(input slot_t s);
    return s + 2'd1;
  endfunction

endpackage

// File: rtl/slot_counter.sv
// Modulo-4 slot position counter with a force-to-1 load.
// A word accepted as slot 0 is consumed in that same cycle, so the counter jumps straight to 1.
module slot_counter
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  load1,
  output slot_t cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= SLOT_FIRST;
    end else if (load1) begin
      cnt <= 2'd1;
    end else if (inc) begin
      cnt <= slot_inc(cnt);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: aligns on sof, buffers slots 0..2,
// and publishes a full frame on the slot-3 word as one registered 4-word output.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   HUNT  | not aligned; words without sof are dropped silently
//   SYNC  | aligned; slot counter tracks the next expected word
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sof,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic         out_valid,
  output logic [1:0]   slot,
  output logic         locked,
  output logic         frame_err
);

  state_t             r_state;
  logic [W-1:0]       r_buf [N_BUF];

  state_t             w_nxt_state;
  logic               w_inc;
  logic               w_load1;
  logic [N_BUF-1:0]   w_buf_we;
  logic               w_ld_out;
  logic               w_err;
  slot_t              w_slot;

  slot_counter u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inc),
    .load1 (w_load1),
    .cnt   (w_slot)
  );

  assign slot = w_slot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_inc       = 1'b0;
    w_load1     = 1'b0;
    w_buf_we    = '0;
    w_ld_out    = 1'b0;
    w_err       = 1'b0;

    if (din_valid) begin
      unique case (r_state)
        HUNT: begin
          if (sof) begin
            w_buf_we[0] = 1'b1;
            w_load1     = 1'b1;
            w_nxt_state = SYNC;
          end
        end
        SYNC: begin
          if (sof) begin
            // Any sof restarts the frame; mid-frame it also flags the dropped partial frame.
            w_buf_we[0] = 1'b1;
            w_load1     = 1'b1;
            w_err       = (w_slot != SLOT_FIRST);
          end else begin
            unique case (w_slot)
              2'd0: begin
                w_err       = 1'b1;
                w_nxt_state = HUNT;
              end
              2'd1: begin
                w_buf_we[1] = 1'b1;
                w_inc       = 1'b1;
              end
              2'd2: begin
                w_buf_we[2] = 1'b1;
                w_inc       = 1'b1;
              end
              default: begin
                w_ld_out = 1'b1;
                w_inc    = 1'b1;
              end
            endcase
          end
        end
        default: w_nxt_state = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BUF; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BUF; i++) begin
        if (w_buf_we[i]) begin
          r_buf[i] <= din;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      locked    <= 1'b0;
    end else begin
      if (w_ld_out) begin
        out0 <= r_buf[0];
        out1 <= r_buf[1];
        out2 <= r_buf[2];
        out3 <= din;
      end
      out_valid <= w_ld_out;
      frame_err <= w_err;
      locked    <= (w_nxt_state == SYNC);
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed scenarios then random traffic, every cycle
// compared against a frame-level model built from a queue of accepted words.
module tb_tdm_demux4;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sof;
  logic [W-1:0] out0, out1, out2, out3;
  logic         out_valid;
  logic [1:0]   slot;
  logic         locked;
  logic         frame_err;

  int n_checks;
  int n_errors;

  logic [W-1:0] m_q [$];
  bit           m_lock;
  logic [W-1:0] m_out [4];
  bit           m_ov;
  bit           m_fe;

  tdm_demux4 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .sof       (sof),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .slot      (slot),
    .locked    (locked),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_lock = 1'b0;
    m_ov   = 1'b0;
    m_fe   = 1'b0;
    for (int i = 0; i < 4; i++) m_out[i] = '0;
  endtask

  // A frame is the queue of words accepted since the last sof; it publishes at 4 words.
  task automatic model_step(input bit v, input bit s, input logic [W-1:0] d);
    m_ov = 1'b0;
    m_fe = 1'b0;
    if (v) begin
      if (s) begin
        if (m_lock && m_q.size() != 0) m_fe = 1'b1;
        m_q.delete();
        m_q.push_back(d);
        m_lock = 1'b1;
      end else if (m_lock) begin
        if (m_q.size() == 0) begin
          m_fe   = 1'b1;
          m_lock = 1'b0;
        end else begin
          m_q.push_back(d);
          if (m_q.size() == 4) begin
            for (int i = 0; i < 4; i++) m_out[i] = m_q[i];
            m_ov = 1'b1;
            m_q.delete();
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("out0", 32'(out0), 32'(m_out[0]));
    check("out1", 32'(out1), 32'(m_out[1]));
    check("out2", 32'(out2), 32'(m_out[2]));
    check("out3", 32'(out3), 32'(m_out[3]));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("frame_err", 32'(frame_err), 32'(m_fe));
    check("locked", 32'(locked), 32'(m_lock));
    check("slot", 32'(slot), 32'(m_q.size()));
  endtask

  task automatic step(input bit v, input bit s, input logic [W-1:0] d);
    din_valid = v;
    sof       = s;
    din       = d;
    @(posedge clk);
    #1;
    model_step(v, s, d);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    sof       = 1'b0;
    model_reset();

    #12;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // basic frame
    step(1, 1, 8'h11);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    step(1, 0, 8'h44);
    check("basic_out0", 32'(out0), 32'h11);
    check("basic_out3", 32'(out3), 32'h44);
    check("basic_valid", 32'(out_valid), 32'h1);
    idle(1);
    check("basic_valid_pulse", 32'(out_valid), 32'h0);

    // gapped frame
    step(1, 1, 8'h11); idle(2);
    step(1, 0, 8'h22); idle(2);
    step(1, 0, 8'h33); idle(2);
    step(1, 0, 8'h44);
    check("gap_valid", 32'(out_valid), 32'h1);
    idle(2);

    // hunt: missing sof drops to HUNT, then words discarded silently
    step(1, 0, 8'h99);
    step(1, 0, 8'hAA);
    step(1, 0, 8'hBB);
    check("hunt_noerr", 32'(frame_err), 32'h0);
    step(1, 1, 8'h5A); step(1, 0, 8'h6B); step(1, 0, 8'h7C); step(1, 0, 8'h8D);
    check("hunt_out1", 32'(out1), 32'h6B);

    // early sof; sof right after slot 3 is legal
    step(1, 1, 8'h01);
    step(1, 0, 8'h02);
    step(1, 1, 8'h10);
    check("early_err", 32'(frame_err), 32'h1);
    check("early_locked", 32'(locked), 32'h1);
    step(1, 0, 8'h20); step(1, 0, 8'h30); step(1, 0, 8'h40);
    check("early_out0", 32'(out0), 32'h10);

    // missing sof after good frame
    step(1, 0, 8'h55);
    check("miss_err", 32'(frame_err), 32'h1);
    check("miss_locked", 32'(locked), 32'h0);
    check("miss_hold", 32'(out3), 32'h40);

    // async reset mid-frame
    step(1, 1, 8'hC1);
    step(1, 0, 8'hC2);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 0, 8'hC3);
    step(1, 0, 8'hC4);
    check("rst_novalid", 32'(out_valid), 32'h0);
    step(1, 1, 8'hD1); step(1, 0, 8'hD2); step(1, 0, 8'hD3); step(1, 0, 8'hD4);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bit v;
      bit s;
      v = ($urandom_range(0, 3) != 0);
      if (m_q.size() == 0) s = ($urandom_range(0, 9) != 0);
      else                 s = ($urandom_range(0, 11) == 0);
      step(v, s, W'($urandom));
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
